// File: rtl/arbiter.sv
// Round-robin arbiter granting one requester at a time for up to BURST accepted selects.
// Optional feature macro ARBITER_LOCK_EN adds input lck, which holds a grant past the BURST limit.
module arbiter #(
    parameter int ARGC  = 2,
    parameter int BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ARGC-1:0]         req_stb,
    output logic                    sel_stb,
    output logic [$clog2(ARGC)-1:0] sel_dat,
    input  logic                    sel_rdy,
`ifdef ARBITER_LOCK_EN
    input  logic                    lck,
`endif
    output logic                    busy
);

    localparam int IW = $clog2(ARGC);
    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(ARGC - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_ptr_nxt;
    logic [IW-1:0] r_sel_dat;
    logic [IW-1:0] w_sel_dat_nxt;
    logic [BW-1:0] r_beats;
    logic [BW-1:0] w_beats_nxt;
    logic          r_sel_stb;
    logic          w_sel_stb_nxt;
    logic          r_busy;
    logic          r_armed;

    logic            w_accept;
    logic            w_cur_req;
    logic            w_lock;
    logic            w_continue;
    logic            w_release;
    logic [IW-1:0]   w_rel_ptr;
    logic [ARGC-1:0] w_rel_mask;
    logic            w_idle_found;
    logic [IW-1:0]   w_idle_win;
    logic            w_rel_found;
    logic [IW-1:0]   w_rel_win;

    // First requesting index at or above start, else the lowest requesting index overall.
    function automatic logic [IW:0] rr_pick(input logic [ARGC-1:0] req, input logic [IW-1:0] start);
        logic          found;
        logic [IW-1:0] win;
        found = 1'b0;
        win   = '0;
        for (int i = ARGC - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                win   = IW'(i);
            end
        end
        for (int i = ARGC - 1; i >= 0; i--) begin
            if (req[i] && (i >= int'(start))) begin
                win = IW'(i);
            end
        end
        return {found, win};
    endfunction

`ifdef ARBITER_LOCK_EN
    assign w_lock = lck;
`else
    assign w_lock = 1'b0;
`endif

    assign w_accept   = r_sel_stb & sel_rdy;
    assign w_cur_req  = req_stb[r_sel_dat];
    assign w_continue = w_accept & w_cur_req & ((r_beats != LAST_BEAT) | w_lock);
    assign w_release  = (r_state == ST_GRANT) & ~w_continue & (w_accept | ~w_cur_req);

    // The releasing requester sits out only the re-arbitration of its own release cycle.
    assign w_rel_ptr  = (r_sel_dat == LAST_IDX) ? '0 : r_sel_dat + IW'(1);
    assign w_rel_mask = req_stb & ~(ARGC'(1) << r_sel_dat);

    assign {w_idle_found, w_idle_win} = rr_pick(req_stb, r_ptr);
    assign {w_rel_found, w_rel_win}   = rr_pick(w_rel_mask, w_rel_ptr);

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_sel_dat_nxt = r_sel_dat;
        w_beats_nxt   = r_beats;
        w_sel_stb_nxt = r_sel_stb;

        case (r_state)
            ST_IDLE: begin
                w_sel_stb_nxt = 1'b0;
                if (r_armed && w_idle_found) begin
                    w_state_nxt   = ST_GRANT;
                    w_sel_stb_nxt = 1'b1;
                    w_sel_dat_nxt = w_idle_win;
                    w_beats_nxt   = '0;
                end
            end
            ST_GRANT: begin
                if (w_continue) begin
                    if (r_beats != LAST_BEAT) begin
                        w_beats_nxt = r_beats + BW'(1);
                    end
                end else if (w_release) begin
                    w_ptr_nxt = w_rel_ptr;
                    if (w_rel_found) begin
                        w_sel_dat_nxt = w_rel_win;
                        w_beats_nxt   = '0;
                        w_sel_stb_nxt = 1'b1;
                    end else begin
                        w_state_nxt   = ST_IDLE;
                        w_sel_stb_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_sel_stb_nxt = 1'b0;
            end
        endcase
    end

    // r_armed keeps the first edge after reset release from issuing a select.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_sel_dat <= '0;
            r_beats   <= '0;
            r_sel_stb <= 1'b0;
            r_busy    <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_sel_dat <= w_sel_dat_nxt;
            r_beats   <= w_beats_nxt;
            r_sel_stb <= w_sel_stb_nxt;
            r_busy    <= (w_state_nxt == ST_GRANT);
            r_armed   <= 1'b1;
        end
    end

    assign sel_stb = r_sel_stb;
    assign sel_dat = r_sel_dat;
    assign busy    = r_busy;

endmodule

// File: tb/tb_arbiter.sv
// Testbench for arbiter (ARGC=4, BURST=2): directed scenarios plus randomized traffic
// checked against a rule-level round-robin model.
module tb_arbiter;

    localparam int ARGC  = 4;
    localparam int BURST = 2;

    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic [3:0] req_stb = '0;
    logic       sel_rdy = 1'b0;
    logic       lck_v   = 1'b0;
    logic       sel_stb;
    logic [1:0] sel_dat;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    arbiter #(.ARGC(ARGC), .BURST(BURST)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_stb (req_stb),
        .sel_stb (sel_stb),
        .sel_dat (sel_dat),
        .sel_rdy (sel_rdy),
`ifdef ARBITER_LOCK_EN
        .lck     (lck_v),
`endif
        .busy    (busy)
    );

    // Reference model: who owns the grant, how many beats it has used, where the search starts.
    bit m_live;
    bit m_grant;
    int m_sel;
    int m_beats;
    int m_ptr;

    function automatic int pick(input logic [ARGC-1:0] req, input int start, input int excl);
        int order[$];
        for (int k = 0; k < ARGC; k++) order.push_back((start + k) % ARGC);
        foreach (order[j]) if (order[j] != excl && req[order[j]]) return order[j];
        return -1;
    endfunction

    task automatic model_reset();
        m_live  = 0;
        m_grant = 0;
        m_sel   = 0;
        m_beats = 0;
        m_ptr   = 0;
    endtask

    task automatic model_edge(input logic [ARGC-1:0] req, input logic rdy, input logic lk);
        int w;
        if (!m_live) begin
            m_live = 1;
        end else if (!m_grant) begin
            w = pick(req, m_ptr, -1);
            if (w >= 0) begin
                m_grant = 1;
                m_sel   = w;
                m_beats = 0;
            end
        end else if (rdy && req[m_sel] && (lk || m_beats < BURST - 1)) begin
            m_beats = (m_beats + 1 > BURST - 1) ? BURST - 1 : m_beats + 1;
        end else if (rdy || !req[m_sel]) begin
            m_ptr = (m_sel + 1) % ARGC;
            w = pick(req, m_ptr, m_sel);
            if (w >= 0) begin
                m_sel   = w;
                m_beats = 0;
            end else begin
                m_grant = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(req_stb, sel_rdy, lck_v);
        #1;
    endtask

    // Leaves rst released between edges; the following edge is the no-select edge.
    task automatic do_reset();
        rst     = 1'b0;
        req_stb = '0;
        sel_rdy = 1'b0;
        lck_v   = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        n_vec++;
        if (sel_stb !== 1'b0 || busy !== 1'b0 || sel_dat !== 2'd0) begin
            n_err++;
            $display("FAIL reset_state: stb=%b busy=%b dat=%0d, want 0 0 0", sel_stb, busy, sel_dat);
        end
        @(posedge clk);
        #1;
        rst     = 1'b1;
        req_stb = 4'b1111;
        tick();
        n_vec++;
        if (sel_stb !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL release_edge_no_select: stb=%b busy=%b, want 0 0", sel_stb, busy);
        end
        tick();
        n_vec++;
        if (sel_stb !== 1'b1 || sel_dat !== 2'd0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL first_grant: stb=%b dat=%0d busy=%b, want 1 0 1", sel_stb, sel_dat, busy);
        end
    endtask

    task automatic test_stream();
        int exp_seq[6] = '{0, 0, 2, 2, 0, 0};
        do_reset();
        req_stb = 4'b0101;
        sel_rdy = 1'b1;
        tick();
        for (int c = 0; c < 6; c++) begin
            tick();
            n_vec++;
            if (sel_stb !== 1'b1 || int'(sel_dat) != exp_seq[c]) begin
                n_err++;
                $display("FAIL stream_c%0d: stb=%b dat=%0d, want 1 %0d", c, sel_stb, sel_dat, exp_seq[c]);
            end
        end
    endtask

    task automatic test_stale();
        logic [3:0] pat[2]  = '{4'b1000, 4'b0010};
        int         own[2]  = '{3, 1};
        int         nxt[2]  = '{0, 2};
        for (int s = 0; s < 2; s++) begin
            do_reset();
            tick();
            req_stb = pat[s];
            tick();
            n_vec++;
            if (sel_stb !== 1'b1 || int'(sel_dat) != own[s] || busy !== 1'b1) begin
                n_err++;
                $display("FAIL stale_grant_%0d: stb=%b dat=%0d busy=%b, want 1 %0d 1", s, sel_stb, sel_dat, busy, own[s]);
            end
            req_stb = 4'b0000;
            tick();
            n_vec++;
            if (sel_stb !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL stale_drop_%0d: stb=%b busy=%b, want 0 0", s, sel_stb, busy);
            end
            req_stb = 4'b1111;
            tick();
            n_vec++;
            if (sel_stb !== 1'b1 || int'(sel_dat) != nxt[s]) begin
                n_err++;
                $display("FAIL stale_ptr_%0d: stb=%b dat=%0d, want 1 %0d", s, sel_stb, sel_dat, nxt[s]);
            end
        end
    endtask

    task automatic test_hold();
        do_reset();
        tick();
        req_stb = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_vec++;
            if (sel_stb !== 1'b1 || sel_dat !== 2'd1) begin
                n_err++;
                $display("FAIL hold_c%0d: stb=%b dat=%0d, want 1 1", c, sel_stb, sel_dat);
            end
        end
        sel_rdy = 1'b1;
        tick();
        n_vec++;
        if (sel_stb !== 1'b1 || sel_dat !== 2'd1) begin
            n_err++;
            $display("FAIL hold_first_accept: stb=%b dat=%0d, want 1 1", sel_stb, sel_dat);
        end
        tick();
        n_vec++;
        if (sel_stb !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL hold_burst_release: stb=%b busy=%b, want 0 0", sel_stb, busy);
        end
        tick();
        n_vec++;
        if (sel_stb !== 1'b1 || sel_dat !== 2'd1) begin
            n_err++;
            $display("FAIL hold_regrant: stb=%b dat=%0d, want 1 1", sel_stb, sel_dat);
        end
    endtask

    task automatic test_round_robin();
        int exp_acc[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
        int got[$];
        int budget = 40;
        do_reset();
        req_stb = 4'b1111;
        tick();
        sel_rdy = 1'b1;
        while (got.size() < 8 && budget > 0) begin
            if (sel_stb && sel_rdy) got.push_back(int'(sel_dat));
            tick();
            sel_rdy = ~sel_rdy;
            budget--;
        end
        n_vec++;
        if (got.size() != 8) begin
            n_err++;
            $display("FAIL rr_budget: saw %0d accepts, want 8", got.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                n_vec++;
                if (got[k] != exp_acc[k]) begin
                    n_err++;
                    $display("FAIL rr_accept_%0d: dat=%0d, want %0d", k, got[k], exp_acc[k]);
                end
            end
            n_vec++;
            if (sel_stb !== 1'b1 || sel_dat !== 2'd0) begin
                n_err++;
                $display("FAIL rr_wrap: stb=%b dat=%0d, want 1 0", sel_stb, sel_dat);
            end
        end
    endtask

    task automatic test_reset_midgrant();
        do_reset();
        tick();
        req_stb = 4'b0100;
        tick();
        n_vec++;
        if (sel_stb !== 1'b1 || sel_dat !== 2'd2) begin
            n_err++;
            $display("FAIL midgrant_setup: stb=%b dat=%0d, want 1 2", sel_stb, sel_dat);
        end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (sel_stb !== 1'b0 || busy !== 1'b0 || sel_dat !== 2'd0) begin
            n_err++;
            $display("FAIL midgrant_async_reset: stb=%b busy=%b dat=%0d, want 0 0 0", sel_stb, busy, sel_dat);
        end
        #1;
        rst = 1'b1;
        tick();
        n_vec++;
        if (sel_stb !== 1'b0) begin
            n_err++;
            $display("FAIL midgrant_release_edge: stb=%b, want 0", sel_stb);
        end
        tick();
        n_vec++;
        if (sel_stb !== 1'b1 || sel_dat !== 2'd2) begin
            n_err++;
            $display("FAIL midgrant_regrant: stb=%b dat=%0d, want 1 2", sel_stb, sel_dat);
        end
    endtask

`ifdef ARBITER_LOCK_EN
    task automatic test_lock();
        do_reset();
        lck_v   = 1'b1;
        req_stb = 4'b0011;
        sel_rdy = 1'b1;
        tick();
        tick();
        for (int c = 0; c < 6; c++) begin
            tick();
            n_vec++;
            if (sel_stb !== 1'b1 || sel_dat !== 2'd0) begin
                n_err++;
                $display("FAIL lock_accept_%0d: stb=%b dat=%0d, want 1 0", c, sel_stb, sel_dat);
            end
        end
        lck_v = 1'b0;
        tick();
        n_vec++;
        if (sel_stb !== 1'b1 || sel_dat !== 2'd1) begin
            n_err++;
            $display("FAIL lock_release: stb=%b dat=%0d, want 1 1", sel_stb, sel_dat);
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) req_stb = 4'($urandom);
            sel_rdy = ($urandom_range(0, 9) < 6);
`ifdef ARBITER_LOCK_EN
            lck_v = ($urandom_range(0, 3) == 0);
`endif
            tick();
            n_vec++;
            if (sel_stb !== m_grant || busy !== m_grant || (m_grant && int'(sel_dat) != m_sel)) begin
                n_err++;
                $display("FAIL random_c%0d: stb=%b busy=%b dat=%0d, want %0d %0d %0d",
                         c, sel_stb, busy, sel_dat, m_grant, m_grant, m_sel);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_stale();
        test_hold();
        test_round_robin();
        test_reset_midgrant();
`ifdef ARBITER_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/arbiter.md
ARBITER -- requirements
Module: arbiter

Interface
REQ-001 SHALL have parameter ARGC, default 2, number of requesters (>=2).
REQ-002 SHALL have parameter BURST, default 4, max consecutive accepted selects per grant (>=1).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_stb  input  ARGC  per-requester pending-data strobe, bit i high = requester i has an argument offered.
REQ-006 SHALL have port sel_stb  output  1  select valid, registered.
REQ-007 SHALL have port sel_dat  output  $clog2(ARGC)  selected requester index, registered.
REQ-008 SHALL have port sel_rdy  input  1  select accepted by downstream multiplexer.
REQ-009 SHALL have port busy  output  1  high while state is GRANT.

Function
REQ-010 SHALL implement states IDLE and GRANT, plus round-robin pointer ptr (index) and beat counter beats (0..BURST-1).
REQ-011 Winner SHALL be the first index i with req_stb[i] high, searching ptr, ptr+1, ... modulo ARGC.
REQ-012 IDLE: if any req_stb bit high, next cycle sel_stb=1, sel_dat=winner, beats=0, state GRANT; else remain IDLE, sel_stb=0; latency request-to-sel_stb exactly 1 cycle.
REQ-013 Accept SHALL occur on a cycle with sel_stb and sel_rdy both high.
REQ-014 While sel_stb high and not accepted, sel_dat SHALL remain stable, except under REQ-016.
REQ-015 On accept, continue when req_stb[sel_dat] high and beats<BURST-1: sel_dat unchanged, sel_stb stays 1, beats+1.
REQ-016 Stale drop: in GRANT with sel_stb high, no accept and req_stb[sel_dat] low, SHALL release as in REQ-017 next cycle.
REQ-017 Release (accept without continue, or stale drop): ptr=sel_dat+1 mod ARGC; re-arbitrate in the same cycle over req_stb with that ptr, excluding current sel_dat; if winner exists, sel_dat=winner, beats=0, sel_stb=1, no bubble; else sel_stb=0, state IDLE.
REQ-018 Exclusion in REQ-017 SHALL apply only to the release cycle; the released requester is eligible again from the next cycle.
REQ-019 BURST=1 SHALL release on every accept, giving pure per-beat round robin.
REQ-020 ptr SHALL wrap ARGC-1 -> 0; when ARGC is not a power of two, sel_dat SHALL never exceed ARGC-1.
REQ-021 busy SHALL equal (state==GRANT), registered.

Reset
REQ-022 rst low SHALL immediately force state IDLE, sel_stb=0, sel_dat=0, ptr=0, beats=0, busy=0, regardless of clk.
REQ-023 Reset asserted mid-grant SHALL discard the grant; after deassertion first grant follows REQ-012 with ptr=0.
REQ-024 Reset deassertion SHALL take effect at the first clk edge after rst goes high; no select issued on that edge.

Configuration
REQ-025 Macro ARBITER_LOCK_EN defined: SHALL add port lck  input  1 ; accept with lck high SHALL continue whenever req_stb[sel_dat] high, ignoring BURST, and beats saturates at BURST-1.
REQ-026 Macro ARBITER_LOCK_EN undefined: lck port SHALL be absent and BURST limit always applies.

Verification (ARGC=4, BURST=2)
REQ-027 Reset, req_stb=0101, sel_rdy=1 -> sel_dat sequence 0,0,2,2,0,0, one select per cycle, no bubbles.
REQ-028 req_stb=1000 one cycle then 0000, sel_rdy=0 -> sel_stb=1 sel_dat=3 one cycle, then stale drop: sel_stb=0, busy=0, ptr=0.
REQ-029 req_stb=0010 held, sel_rdy=0 for 5 cycles -> sel_stb=1, sel_dat=1 stable all 5 cycles; accept on cycle 6 -> beats=1.
REQ-030 req_stb=1111, sel_rdy toggling 1,0,1,0 -> each index granted exactly 2 accepts in order 0,1,2,3, ptr wraps to 0.
REQ-031 Grant active on index 2, rst low for 1 ns between edges -> sel_stb=0 immediately; after release with req_stb=0100 -> sel_dat=2 one cycle later.
REQ-032 With ARBITER_LOCK_EN, lck=1, req_stb=0011 -> sel_dat=0 for 6 accepts; lck=0 -> release, next sel_dat=1.
